// File: rtl/flipdot_stream_rx_pkg.sv
// Shared constants and types for the flipdot serial stream receiver:
// packet framing bytes, default geometry and the error code encoding.
package flipdot_stream_rx_pkg;

    localparam logic [7:0] HDR_START = 8'h80;
    localparam logic [7:0] HDR_CMD   = 8'h83;
    localparam logic [7:0] PKT_END   = 8'h8F;

    localparam int DEF_LINE_BYTES = 28;
    localparam int DEF_NUM_LINES  = 8;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_FRAMING = 2'd1,
        ERR_SEQ     = 2'd2,
        ERR_ADDR    = 2'd3
    } err_code_e;

endpackage

// File: rtl/flipdot_stream_rx_uart.sv
// 8N1 UART receiver (uart_rx_8n1): mid-bit sampling, glitch rejection on the
// start bit, and a one-cycle byte or framing-error pulse at the stop sample.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 218
) (
    input  logic       ball_clock,
    input  logic       reset,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_e;

    ustate_e       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rxdPrev_q;

    always_ff @(posedge ball_clock or posedge reset) begin
        if (reset) begin
            state_q   <= U_IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            rxdPrev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            rxdPrev_q <= rxd_i;
        end
    end

    // Returning to U_IDLE right at the stop sample lets a start edge that
    // follows with zero idle time be caught on the very next cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bitIdx_d     = bitIdx_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            U_IDLE: begin
                if (rxdPrev_q && !rxd_i) begin
                    state_d = U_START;
                    cnt_d   = '0;
                end
            end
            U_START: begin
                if (cnt_q == HALF) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rxd_i ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxd_i, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = U_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d        = '0;
                    state_d      = U_IDLE;
                    byte_valid_o = rxd_i;
                    frame_err_o  = !rxd_i;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/flipdot_stream_rx.sv
// Flipdot stream receiver: UART front end, packet parser and 224-entry image
// buffer with a registered read port. FLIPDOT_RX_STATS_EN adds event counters.
module flipdot_stream_rx
    import flipdot_stream_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 218,
    parameter int LINE_BYTES   = DEF_LINE_BYTES,
    parameter int NUM_LINES    = DEF_NUM_LINES
) (
    input  logic       ball_clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic [7:0] rd_index,
    output logic [6:0] rd_data,
    output logic       line_done,
    output logic [2:0] line_addr,
    output logic       frame_done,
    output logic       err_pulse,
    output logic [1:0] err_code
`ifdef FLIPDOT_RX_STATS_EN
    ,
    input  logic        stat_clr,
    output logic [15:0] stat_lines,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_errs
`endif
);

    localparam int DEPTH = LINE_BYTES * NUM_LINES;

    typedef enum logic [2:0] {P_IDLE, P_CMD, P_ADDR, P_DATA, P_END} pstate_e;

    logic       rxdMeta_q, rxdSync_q;
    logic       byteValid, frameErr;
    logic [7:0] rxByte;

    always_ff @(posedge ball_clock or posedge reset) begin
        if (reset) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) uUart (
        .ball_clock  (ball_clock),
        .reset       (reset),
        .rxd_i       (rxdSync_q),
        .byte_valid_o(byteValid),
        .byte_o      (rxByte),
        .frame_err_o (frameErr)
    );

    pstate_e    pState_q, pState_d;
    logic [2:0] addr_q, addr_d;
    logic [4:0] count_q, count_d;
    logic       lineDone_q, lineDone_d;
    logic [2:0] lineAddr_q, lineAddr_d;
    logic       frameDone_q, frameDone_d;
    logic       errPulse_q, errPulse_d;
    err_code_e  errCode_q, errCode_d;
    logic       errNow;
    err_code_e  errKind;
    logic       wrEn;
    logic [7:0] wrIdx;
    logic [6:0] rdData_q;
    logic [6:0] buffer_q [0:DEPTH-1];

    assign wrIdx = 8'(addr_q) * 8'(LINE_BYTES) + 8'(count_q);

    always_ff @(posedge ball_clock or posedge reset) begin
        if (reset) begin
            pState_q    <= P_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            lineDone_q  <= 1'b0;
            lineAddr_q  <= '0;
            frameDone_q <= 1'b0;
            errPulse_q  <= 1'b0;
            errCode_q   <= ERR_NONE;
        end else begin
            pState_q    <= pState_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            lineDone_q  <= lineDone_d;
            lineAddr_q  <= lineAddr_d;
            frameDone_q <= frameDone_d;
            errPulse_q  <= errPulse_d;
            errCode_q   <= errCode_d;
        end
    end

    // A framing error overrides whatever byte the parser would have seen;
    // any other error resynchronises on the offending byte if it is a header.
    always_comb begin
        pState_d    = pState_q;
        addr_d      = addr_q;
        count_d     = count_q;
        lineDone_d  = 1'b0;
        lineAddr_d  = lineAddr_q;
        frameDone_d = 1'b0;
        errPulse_d  = 1'b0;
        errCode_d   = errCode_q;
        errNow      = 1'b0;
        errKind     = ERR_SEQ;
        wrEn        = 1'b0;
        if (frameErr) begin
            errPulse_d = 1'b1;
            errCode_d  = ERR_FRAMING;
            pState_d   = P_IDLE;
        end else if (byteValid) begin
            unique case (pState_q)
                P_IDLE: if (rxByte == HDR_START) pState_d = P_CMD;
                P_CMD: begin
                    if (rxByte == HDR_CMD) pState_d = P_ADDR;
                    else errNow = 1'b1;
                end
                P_ADDR: begin
                    if (rxByte < 8'(NUM_LINES)) begin
                        addr_d   = rxByte[2:0];
                        count_d  = '0;
                        pState_d = P_DATA;
                    end else begin
                        errNow  = 1'b1;
                        errKind = ERR_ADDR;
                    end
                end
                P_DATA: begin
                    if (!rxByte[7]) begin
                        wrEn = 1'b1;
                        if (count_q == 5'(LINE_BYTES - 1)) pState_d = P_END;
                        else count_d = count_q + 5'd1;
                    end else begin
                        errNow = 1'b1;
                    end
                end
                P_END: begin
                    if (rxByte == PKT_END) begin
                        lineDone_d  = 1'b1;
                        lineAddr_d  = addr_q;
                        frameDone_d = (addr_q == 3'(NUM_LINES - 1));
                        pState_d    = P_IDLE;
                    end else begin
                        errNow = 1'b1;
                    end
                end
                default: pState_d = P_IDLE;
            endcase
            if (errNow) begin
                errPulse_d = 1'b1;
                errCode_d  = errKind;
                pState_d   = (rxByte == HDR_START) ? P_CMD : P_IDLE;
            end
        end
    end

    // Read samples the pre-write contents, so a same-cycle write to the read
    // index shows up one read later.
    always_ff @(posedge ball_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) buffer_q[i] <= '0;
            rdData_q <= '0;
        end else begin
            if (wrEn) buffer_q[wrIdx] <= rxByte[6:0];
            if (rd_index < 8'(DEPTH)) rdData_q <= buffer_q[rd_index];
            else rdData_q <= '0;
        end
    end

    assign rd_data    = rdData_q;
    assign line_done  = lineDone_q;
    assign line_addr  = lineAddr_q;
    assign frame_done = frameDone_q;
    assign err_pulse  = errPulse_q;
    assign err_code   = errCode_q;

`ifdef FLIPDOT_RX_STATS_EN
    logic [15:0] statLines_q, statFrames_q, statErrs_q;

    always_ff @(posedge ball_clock or posedge reset) begin
        if (reset) begin
            statLines_q  <= '0;
            statFrames_q <= '0;
            statErrs_q   <= '0;
        end else if (stat_clr) begin
            statLines_q  <= '0;
            statFrames_q <= '0;
            statErrs_q   <= '0;
        end else begin
            if (lineDone_q && statLines_q != 16'hFFFF) statLines_q <= statLines_q + 16'd1;
            if (frameDone_q && statFrames_q != 16'hFFFF) statFrames_q <= statFrames_q + 16'd1;
            if (errPulse_q && statErrs_q != 16'hFFFF) statErrs_q <= statErrs_q + 16'd1;
        end
    end

    assign stat_lines  = statLines_q;
    assign stat_frames = statFrames_q;
    assign stat_errs   = statErrs_q;
`endif

endmodule

// File: tb/tb_flipdot_stream_rx.sv
// Self-checking bench for flipdot_stream_rx: serialises packets onto rxd and
// compares against a packet-level model of the image buffer and event counts.
module tb_flipdot_stream_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 224;

    logic       ball_clock = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rd_index;
    logic [6:0] rd_data;
    logic       line_done;
    logic [2:0] line_addr;
    logic       frame_done;
    logic       err_pulse;
    logic [1:0] err_code;
`ifdef FLIPDOT_RX_STATS_EN
    logic        statClr = 1'b0;
    logic [15:0] statLines, statFrames, statErrs;
`endif

    flipdot_stream_rx #(.CLKS_PER_BIT(CPB)) dut (
        .ball_clock(ball_clock),
        .reset     (reset),
        .rxd       (rxd),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .line_done (line_done),
        .line_addr (line_addr),
        .frame_done(frame_done),
        .err_pulse (err_pulse),
        .err_code  (err_code)
`ifdef FLIPDOT_RX_STATS_EN
        ,
        .stat_clr   (statClr),
        .stat_lines (statLines),
        .stat_frames(statFrames),
        .stat_errs  (statErrs)
`endif
    );

    always #5 ball_clock = ~ball_clock;

    int checkCount = 0;
    int errorCount = 0;
    int expBuf [DEPTH];
    logic [7:0] lineData [28];

    // Event monitor: only this process writes these counters.
    int lineCount = 0, frameCount = 0, errCount = 0, lastLineAddr = 0, badCoincide = 0;

    always @(negedge ball_clock) begin
        if (!reset) begin
            if (line_done) begin
                lineCount++;
                lastLineAddr = int'(line_addr);
            end
            if (err_pulse) errCount++;
            if (frame_done) begin
                frameCount++;
                if (!line_done || line_addr != 3'd7) badCoincide++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badStop);
        rxd = 1'b0;
        repeat (CPB) @(negedge ball_clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge ball_clock);
        end
        rxd = !badStop;
        repeat (CPB) @(negedge ball_clock);
        rxd = 1'b1;
    endtask

    task automatic idleBits(input int n);
        rxd = 1'b1;
        repeat (n * CPB) @(negedge ball_clock);
    endtask

    task automatic sendLine(input int addr, input bit glitch);
        applyStimulus(8'h80, 1'b0);
        if (glitch) begin
            rxd = 1'b0;
            @(negedge ball_clock);
            rxd = 1'b1;
            idleBits(2);
        end
        applyStimulus(8'h83, 1'b0);
        applyStimulus(8'(addr), 1'b0);
        for (int j = 0; j < 28; j++) applyStimulus(lineData[j], 1'b0);
        applyStimulus(8'h8F, 1'b0);
    endtask

    task automatic modelWrite(input int addr, input int count);
        for (int j = 0; j < count; j++) expBuf[addr * 28 + j] = int'(lineData[j] & 8'h7F);
    endtask

    task automatic fillRandom();
        for (int j = 0; j < 28; j++) lineData[j] = 8'($urandom_range(0, 127));
    endtask

    task automatic readBuf(input int idx, output logic [6:0] val);
        rd_index = 8'(idx);
        @(negedge ball_clock);
        val = rd_data;
    endtask

    task automatic checkAll(input string tag);
        logic [6:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            readBuf(i, v);
            checkOutput($sformatf("%s_buf%0d", tag, i), 32'(v), 32'(expBuf[i]));
        end
    endtask

    initial begin
        int l0, f0, e0, a;
        logic [6:0] v;
        logic [7:0] b;

        reset = 1'b1;
        rxd = 1'b1;
        rd_index = '0;
        for (int i = 0; i < DEPTH; i++) expBuf[i] = 0;
        repeat (3) @(negedge ball_clock);
        reset = 1'b0;
        @(negedge ball_clock);
        checkOutput("rstLineDone", 32'(line_done), 0);
        checkOutput("rstLineAddr", 32'(line_addr), 0);
        checkOutput("rstFrameDone", 32'(frame_done), 0);
        checkOutput("rstErrPulse", 32'(err_pulse), 0);
        checkOutput("rstErrCode", 32'(err_code), 0);
        checkOutput("rstRdData", 32'(rd_data), 0);

        // Line 2 with data 01..1C
        for (int j = 0; j < 28; j++) lineData[j] = 8'(j + 1);
        l0 = lineCount; f0 = frameCount;
        sendLine(2, 1'b0);
        modelWrite(2, 28);
        idleBits(1);
        checkOutput("t1Lines", 32'(lineCount - l0), 1);
        checkOutput("t1LineAddr", 32'(line_addr), 2);
        checkOutput("t1Frames", 32'(frameCount - f0), 0);
        readBuf(56, v);
        checkOutput("t1Idx56", 32'(v), 32'h01);
        readBuf(83, v);
        checkOutput("t1Idx83", 32'(v), 32'h1C);

        // Full frame, line k byte j = (k*28+j) & 7F
        l0 = lineCount; f0 = frameCount;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 28; j++) lineData[j] = 8'((k * 28 + j) & 8'h7F);
            sendLine(k, 1'b0);
            modelWrite(k, 28);
            if (k == 6) checkOutput("t2FramesEarly", 32'(frameCount - f0), 0);
        end
        idleBits(1);
        checkOutput("t2Lines", 32'(lineCount - l0), 8);
        checkOutput("t2Frames", 32'(frameCount - f0), 1);
        checkOutput("t2Coincide", 32'(badCoincide), 0);
        checkAll("t2");
        readBuf(230, v);
        checkOutput("rdOutOfRange", 32'(v), 0);

        // Non-header bytes in idle are ignored silently
        e0 = errCount;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h80) b = 8'h81;
            applyStimulus(b, 1'b0);
        end
        idleBits(1);
        checkOutput("idleIgnored", 32'(errCount - e0), 0);

        // Bad address, then a good line 0
        e0 = errCount; l0 = lineCount;
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h83, 1'b0);
        applyStimulus(8'($urandom_range(8, 127)), 1'b0);
        idleBits(1);
        checkOutput("t3ErrPulses", 32'(errCount - e0), 1);
        checkOutput("t3ErrCode", 32'(err_code), 3);
        fillRandom();
        sendLine(0, 1'b0);
        modelWrite(0, 28);
        idleBits(1);
        checkOutput("t3Lines", 32'(lineCount - l0), 1);
        checkOutput("t3LineAddr", 32'(lastLineAddr), 0);

        // Framing error mid-data, partial writes stay, next line accepted
        e0 = errCount; l0 = lineCount;
        a = $urandom_range(0, 7);
        f0 = $urandom_range(1, 20);
        fillRandom();
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h83, 1'b0);
        applyStimulus(8'(a), 1'b0);
        for (int j = 0; j < f0; j++) applyStimulus(lineData[j], 1'b0);
        modelWrite(a, f0);
        applyStimulus(8'($urandom_range(0, 127)), 1'b1);
        idleBits(2);
        checkOutput("t4ErrPulses", 32'(errCount - e0), 1);
        checkOutput("t4ErrCode", 32'(err_code), 1);
        checkOutput("t4NoLine", 32'(lineCount - l0), 0);
        a = $urandom_range(0, 7);
        fillRandom();
        sendLine(a, 1'b0);
        modelWrite(a, 28);
        idleBits(1);
        checkOutput("t4Lines", 32'(lineCount - l0), 1);
        checkOutput("t4LineAddr", 32'(lastLineAddr), 32'(a));

        // Header inside data: error 2, resync without losing the packet
        e0 = errCount; l0 = lineCount;
        fillRandom();
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h83, 1'b0);
        applyStimulus(8'h01, 1'b0);
        for (int j = 0; j < 5; j++) applyStimulus(lineData[j], 1'b0);
        modelWrite(1, 5);
        fillRandom();
        sendLine(1, 1'b0);
        modelWrite(1, 28);
        idleBits(1);
        checkOutput("t5ErrPulses", 32'(errCount - e0), 1);
        checkOutput("t5ErrCode", 32'(err_code), 2);
        checkOutput("t5Lines", 32'(lineCount - l0), 1);
        checkOutput("t5LineAddr", 32'(lastLineAddr), 1);
        checkAll("t5");

        // Reset in the middle of a data byte
        fillRandom();
        applyStimulus(8'h80, 1'b0);
        applyStimulus(8'h83, 1'b0);
        applyStimulus(8'h03, 1'b0);
        for (int j = 0; j < 3; j++) applyStimulus(lineData[j], 1'b0);
        rxd = 1'b0;
        repeat (CPB * 3) @(negedge ball_clock);
        reset = 1'b1;
        rxd = 1'b1;
        for (int i = 0; i < DEPTH; i++) expBuf[i] = 0;
        repeat (2) @(negedge ball_clock);
        checkOutput("t6RstLineAddr", 32'(line_addr), 0);
        checkOutput("t6RstErrCode", 32'(err_code), 0);
        checkOutput("t6RstRdData", 32'(rd_data), 0);
        reset = 1'b0;
        readBuf(56, v);
        checkOutput("t6ClearedIdx56", 32'(v), 0);

        // Packet right after reset, with a 1-sample glitch after the header
        e0 = errCount; l0 = lineCount;
        a = $urandom_range(0, 7);
        fillRandom();
        sendLine(a, 1'b1);
        modelWrite(a, 28);
        idleBits(1);
        checkOutput("t6GlitchNoErr", 32'(errCount - e0), 0);
        checkOutput("t6Lines", 32'(lineCount - l0), 1);
        checkOutput("t6LineAddr", 32'(line_addr), 32'(a));
        checkAll("t6");

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/flipdot_stream_rx.md
Name: flipdot_stream_rx

Overview:
Receive-side counterpart of the flipdot serial stream generator. It deserialises the 8N1 UART stream, checks each 32-byte line packet, and writes the 7-bit column bytes into a 224-entry (8 sections x 28 columns) image buffer. It sits in the loopback/checker path and as the front end of the flipdot panel emulator. A registered read port lets downstream logic scan the buffer.

Parameters:
CLKS_PER_BIT, 218, ball_clock cycles per UART bit; must be >= 8.
LINE_BYTES, 28, data bytes per packet.
NUM_LINES, 8, packets per frame; the address byte ranges 0..NUM_LINES-1.

Ports:
ball_clock  in  1  system clock
reset  in  1  asynchronous, active-high
rxd  in  1  serial input, idle high, asynchronous to ball_clock
rd_index  in  8  buffer read index, 0..223
rd_data  out  7  buffer contents at rd_index, 1-cycle latency
line_done  out  1  1-cycle pulse when a packet is accepted
line_addr  out  3  address of the last accepted packet
frame_done  out  1  1-cycle pulse, coincident with line_done when line_addr==NUM_LINES-1
err_pulse  out  1  1-cycle pulse on any error
err_code  out  2  last error: 0 none, 1 framing, 2 header/sequence, 3 bad address

Behaviour:
- Clock and reset: reset (asynchronous, active-high) and ball_clock are already decided.
- Reset values: all outputs 0; buffer cleared to 0; parser in P_IDLE; UART idle.
- Input sync: rxd passes through a 2-flop synchroniser. The reset value of both flops is 1.
- UART sub-module:
  - In IDLE, a synchronised falling edge starts a byte.
  - The start bit is sampled at CLKS_PER_BIT/2. If it reads high, the event is a glitch: return to IDLE with no output.
  - 8 data bits are sampled LSB first, each CLKS_PER_BIT later, then the stop bit.
  - Stop bit high: byte_valid pulses for 1 cycle at the stop sample.
  - Stop bit low: frame_err pulses and no byte is output.
  - The next start edge is accepted the cycle after the stop sample; back-to-back bytes with zero idle time must work.
- Parser FSM (advances only on byte_valid or frame_err):
  - P_IDLE: 0x80 -> P_CMD; any other byte ignored silently.
  - P_CMD: 0x83 -> P_ADDR; anything else -> error 2.
  - P_ADDR: value < NUM_LINES -> latch addr, clear n, go to P_DATA; else error 3.
  - P_DATA:
    - bit7==0: write buffer[addr*28+n] <= byte[6:0]; n++; after n reaches 27, go to P_END.
    - byte==0x80: error 2.
    - any other byte with bit7 set: error 2.
  - P_END: 0x8F -> line_done, line_addr<=addr, frame_done if addr==7; go to P_IDLE. Anything else -> error 2.
- Error handling:
  - Any error: err_pulse, err_code updated, parser -> P_IDLE.
  - Exception: if the offending byte is 0x80, the parser goes to P_CMD (resync on header).
  - A framing error in any parser state -> error 1, P_IDLE.
  - Partial writes already made to the buffer are not rolled back.
- Arithmetic: the index is addr*28+n, computed 8 bits wide, max 223.
- Read port: rd_data <= buffer[rd_index], registered. rd_index > 223 returns 0.
  - If a read and a write hit the same index in the same cycle, rd_data returns the old value.
- Reset mid-byte or mid-packet: everything returns to the reset state immediately. The next valid 0x80 restarts reception.

Optional Feature:
FLIPDOT_RX_STATS_EN
- Defined: adds outputs stat_lines[15:0], stat_frames[15:0] and stat_errs[15:0].
  - stat_lines increments on line_done, stat_frames on frame_done, stat_errs on err_pulse.
  - Each counter saturates at 0xFFFF and clears on reset.
  - Input stat_clr (1 bit) zeroes all three counters synchronously; stat_clr has priority over an increment in the same cycle.
- Not defined: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Shared constants go in flipdot_param.h: HDR_START=8'h80, HDR_CMD=8'h83, PKT_END=8'h8F, LINE_BYTES=28, NUM_LINES=8, BUF_DEPTH=224.
- The parser state encoding is localparam inside flipdot_stream_rx.
- One sub-module: uart_rx_8n1. Inputs: ball_clock, reset, synchronised rxd. Outputs: byte_valid, byte[7:0], frame_err. Parameter: CLKS_PER_BIT.

Test Plan:
1. Send 80 83 02, data 01..1C, 8F back-to-back, with CLKS_PER_BIT=16 for the bench -> line_done=1 with line_addr=2. Reading index 56 returns 01; index 83 returns 1C; frame_done=0.
2. Send a full 8-packet frame from the stream generator model, where line k data byte j is k*28+j (masked to 7 bits) -> frame_done pulses once, after line 7. Reading all 224 indices matches the model.
3. Send 80 83 09 -> err_code=3 and err_pulse. A following valid packet with address 0 is accepted normally.
4. Send a byte with the stop bit forced low in the middle of P_DATA -> err_code=1 and the parser returns to P_IDLE. The next packet is accepted.
5. Send 80 83 01, then 5 data bytes, then 80 83 01 plus a full packet -> err_code=2 on the second 0x80, then resync with no lost packet. line_done occurs once, for line 1.
6. Assert reset mid-data-byte -> buffer reads 0 and outputs are 0. A packet sent immediately after reset releases is received correctly. A 1-sample low glitch on rxd produces no byte.
